// File: rtl/cpu_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_ctrl_if
// Description : Signal bundle between the board I/O side (buttons, rate,
//               PC / breakpoint inputs) and the cpu_run_ctrl sequencer.
//               master = board/driver side, slave = run-control block.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_run_ctrl_if #(
  parameter int PC_WIDTH  = 4,
  parameter int DIV_WIDTH = 24,
  parameter int CYC_WIDTH = 16
);
  // Board-side requests and configuration
  logic                 run_btn;
  logic                 step_btn;
  logic                 halt_btn;
  logic [DIV_WIDTH-1:0] div_sel;
  logic [PC_WIDTH-1:0]  pc;
  logic [PC_WIDTH-1:0]  bp_addr;
  logic                 bp_valid;

  // Sequencer outputs
  logic                 cpu_en;
  logic [1:0]           state;
  logic [CYC_WIDTH-1:0] cycle_cnt;
  logic                 bp_hit;

  modport master (
    output run_btn, step_btn, halt_btn, div_sel, pc, bp_addr, bp_valid,
    input  cpu_en, state, cycle_cnt, bp_hit
  );

  modport slave (
    input  run_btn, step_btn, halt_btn, div_sel, pc, bp_addr, bp_valid,
    output cpu_en, state, cycle_cnt, bp_hit
  );
endinterface
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_ctrl
// Description : Run-control sequencer for the single-cycle CPU. Produces the
//               one-clock cpu_en step strobe (free-run at a programmable
//               rate, single-step, halt), counts issued strobes, and
//               optionally stops on a PC breakpoint.
//               Optional feature macro: CPU_RUN_CTRL_BREAKPOINT_EN
//               (undefined: BREAK unreachable, bp_hit tied low).
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
  parameter int PC_WIDTH  = 4,
  parameter int DIV_WIDTH = 24,
  parameter int CYC_WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  cpu_run_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } state_t;

  // Button vectors are ordered {halt, step, run}
  localparam int BTN_RUN  = 0;
  localparam int BTN_STEP = 1;
  localparam int BTN_HALT = 2;

  logic [2:0]           btn_meta_q, btn_meta_d;
  logic [2:0]           btn_sync_q, btn_sync_d;
  logic [2:0]           btn_prev_q, btn_prev_d;
  logic [2:0]           btn_ev;

  state_t               state_q, state_d;
  logic                 cpu_en_q, cpu_en_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [CYC_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic                 bp_hit_q, bp_hit_d;
  logic                 skip_q, skip_d;
  logic                 rate_hit;
  logic                 bp_match;

  // Rising edge of the synchronized level: one event per press, however long held
  assign btn_ev   = btn_sync_q & ~btn_prev_q;

  // Lowering div_sel below the running divider fires at once instead of wrapping
  assign rate_hit = (div_q >= bus.div_sel);

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  // Skip lets the first strobe after a resume step off the breakpoint address
  assign bp_match = bus.bp_valid && (bus.pc == bus.bp_addr) && !skip_q;
`else
  logic unused_bp;
  assign bp_match  = 1'b0;
  assign unused_bp = ^{bus.bp_valid, bus.bp_addr, bus.pc, skip_q};
`endif

  // Next-state, strobe, divider and counter computation
  always_comb begin
    btn_meta_d  = {bus.halt_btn, bus.step_btn, bus.run_btn};
    btn_sync_d  = btn_meta_q;
    btn_prev_d  = btn_sync_q;
    state_d     = state_q;
    cpu_en_d    = 1'b0;
    div_d       = div_q;
    bp_hit_d    = bp_hit_q;
    skip_d      = skip_q;
    cycle_cnt_d = cpu_en_q ? (cycle_cnt_q + CYC_WIDTH'(1)) : cycle_cnt_q;

    case (state_q)
      ST_HALT: begin
        if (btn_ev[BTN_HALT]) begin
          state_d = ST_HALT;
        end else if (btn_ev[BTN_STEP]) begin
          state_d = ST_STEP;
        end else if (btn_ev[BTN_RUN]) begin
          state_d = ST_RUN;
          div_d   = '0;
        end
      end

      ST_STEP: begin
        // Entry cycle registers the strobe; the strobe cycle returns to HALT
        if (!cpu_en_q) begin
          cpu_en_d = 1'b1;
        end else begin
          state_d = ST_HALT;
        end
      end

      ST_RUN: begin
        if (btn_ev[BTN_HALT]) begin
          // A strobe due this cycle is dropped; one already high still completes
          state_d = ST_HALT;
          skip_d  = 1'b0;
        end else if (rate_hit) begin
          div_d = '0;
          if (bp_match) begin
            state_d  = ST_BREAK;
            bp_hit_d = 1'b1;
            skip_d   = 1'b0;
          end else begin
            cpu_en_d = 1'b1;
            skip_d   = 1'b0;
          end
        end else begin
          div_d = div_q + DIV_WIDTH'(1);
        end
      end

      ST_BREAK: begin
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        if (btn_ev[BTN_HALT]) begin
          state_d  = ST_HALT;
          bp_hit_d = 1'b0;
        end else if (btn_ev[BTN_STEP]) begin
          state_d  = ST_STEP;
          bp_hit_d = 1'b0;
        end else if (btn_ev[BTN_RUN]) begin
          state_d  = ST_RUN;
          bp_hit_d = 1'b0;
          skip_d   = 1'b1;
          div_d    = '0;
        end
`else
        // Not reachable without the breakpoint feature; recover to HALT
        state_d = ST_HALT;
`endif
      end

      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // State register; async reset also kills an in-flight strobe immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta_q  <= '0;
      btn_sync_q  <= '0;
      btn_prev_q  <= '0;
      state_q     <= ST_HALT;
      cpu_en_q    <= 1'b0;
      div_q       <= '0;
      cycle_cnt_q <= '0;
      bp_hit_q    <= 1'b0;
      skip_q      <= 1'b0;
    end else begin
      btn_meta_q  <= btn_meta_d;
      btn_sync_q  <= btn_sync_d;
      btn_prev_q  <= btn_prev_d;
      state_q     <= state_d;
      cpu_en_q    <= cpu_en_d;
      div_q       <= div_d;
      cycle_cnt_q <= cycle_cnt_d;
      bp_hit_q    <= bp_hit_d;
      skip_q      <= skip_d;
    end
  end

  assign bus.cpu_en    = cpu_en_q;
  assign bus.state     = state_q;
  assign bus.cycle_cnt = cycle_cnt_q;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  assign bus.bp_hit    = bp_hit_q;
`else
  assign bus.bp_hit    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_run_ctrl
// Description : Self-checking bench for cpu_run_ctrl. Expected strobe counts
//               are queued when a scenario is driven and compared when the
//               strobe appears. Define CPU_RUN_CTRL_BREAKPOINT_EN for the
//               breakpoint scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;
  localparam int PW = 4;
  localparam int DW = 24;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   model_cnt = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.PC_WIDTH(PW), .DIV_WIDTH(DW), .CYC_WIDTH(CW)) bus ();

  cpu_run_ctrl #(.PC_WIDTH(PW), .DIV_WIDTH(DW), .CYC_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // The CPU's next address follows the number of executed instructions
  assign bus.pc = bus.cycle_cnt[PW-1:0];

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(input int budget, output bit seen, output int waited);
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < budget) begin
      @(negedge clk);
      waited++;
      if (bus.cpu_en === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic do_halt();
    bus.halt_btn = 1'b1;
    tick(4);
    bus.halt_btn = 1'b0;
    tick(3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.run_btn = 1'b0; bus.step_btn = 1'b0; bus.halt_btn = 1'b0;
    bus.div_sel = '0; bus.bp_addr = '0; bus.bp_valid = 1'b0;
    tick(2);
    n_checks++;
    if ({bus.state, bus.cpu_en, bus.cycle_cnt, bus.bp_hit} !== 8'h00)
      $display("FAIL reset_state state=%0d cpu_en=%b cnt=%0d bp_hit=%b expected all 0",
               bus.state, bus.cpu_en, bus.cycle_cnt, bus.bp_hit);
    else n_pass++;
    rst = 1'b0;
    model_cnt = 0;
    tick(2);
  endtask

  task automatic test_run_rate();
    bit seen; int waited; int exp;
    bus.div_sel = DW'(3);
    bus.run_btn = 1'b1;
    tick(2);
    n_checks++;
    if (bus.state !== 2'd0) $display("FAIL run_latency_early state=%0d expected 0", bus.state);
    else n_pass++;
    tick(1);
    n_checks++;
    if (bus.state !== 2'd1) $display("FAIL run_latency state=%0d expected 1", bus.state);
    else n_pass++;
    bus.run_btn = 1'b0;
    for (int k = 0; k < 5; k++) exp_q.push_back(model_cnt + k);
    for (int p = 0; p < 5; p++) begin
      wait_pulse(8, seen, waited);
      n_checks++;
      if (!seen) begin
        $display("FAIL run_pulse%0d timeout after %0d clk, expected a strobe", p, waited);
      end else begin
        exp = exp_q.pop_front();
        if (bus.cycle_cnt !== CW'(exp) || waited != ((p == 0) ? 4 : 3))
          $display("FAIL run_pulse%0d cnt=%0d gap=%0d expected cnt=%0d gap=%0d",
                   p, bus.cycle_cnt, waited, CW'(exp), (p == 0) ? 4 : 3);
        else n_pass++;
        tick(1);
        n_checks++;
        if (bus.cpu_en !== 1'b0) $display("FAIL run_pulse_width%0d cpu_en=%b expected 0", p, bus.cpu_en);
        else n_pass++;
      end
    end
    exp_q.delete();
    model_cnt += 5;
    n_checks++;
    if (bus.cycle_cnt !== CW'(model_cnt)) $display("FAIL run_count cnt=%0d expected %0d", bus.cycle_cnt, CW'(model_cnt));
    else n_pass++;
    // Halt arrives exactly on the next due strobe, which must be dropped
    bus.halt_btn = 1'b1;
    tick(4);
    n_checks++;
    if (bus.state !== 2'd0 || bus.cpu_en !== 1'b0 || bus.cycle_cnt !== CW'(model_cnt))
      $display("FAIL halt_suppress state=%0d cpu_en=%b cnt=%0d expected 0/0/%0d",
               bus.state, bus.cpu_en, bus.cycle_cnt, CW'(model_cnt));
    else n_pass++;
    bus.halt_btn = 1'b0;
    tick(3);
  endtask

  task automatic test_step_hold();
    int pulses = 0; int exp;
    exp_q.push_back(model_cnt);
    bus.step_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.cpu_en === 1'b1) begin
        pulses++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL step_extra_pulse cnt=%0d expected no strobe", bus.cycle_cnt);
        else begin
          exp = exp_q.pop_front();
          if (bus.cycle_cnt !== CW'(exp) || bus.state !== 2'd2)
            $display("FAIL step_pulse cnt=%0d state=%0d expected %0d/2", bus.cycle_cnt, bus.state, CW'(exp));
          else n_pass++;
        end
      end
    end
    bus.step_btn = 1'b0;
    tick(5);
    exp_q.delete();
    model_cnt += 1;
    n_checks++;
    if (pulses != 1 || bus.state !== 2'd0 || bus.cycle_cnt !== CW'(model_cnt))
      $display("FAIL step_hold pulses=%0d state=%0d cnt=%0d expected 1/0/%0d",
               pulses, bus.state, bus.cycle_cnt, CW'(model_cnt));
    else n_pass++;
  endtask

  task automatic test_div_zero_halt();
    int highs = 0;
    bus.div_sel = '0;
    bus.run_btn = 1'b1;
    tick(3);
    bus.run_btn = 1'b0;
    n_checks++;
    if (bus.state !== 2'd1) $display("FAIL div0_enter state=%0d expected 1", bus.state);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (bus.cpu_en === 1'b1) highs++;
    end
    n_checks++;
    if (highs != 8) $display("FAIL div0_continuous high_cycles=%0d expected 8", highs);
    else n_pass++;
    bus.halt_btn = 1'b1;
    tick(2);
    n_checks++;
    if (bus.cpu_en !== 1'b1) $display("FAIL halt_inflight cpu_en=%b expected 1", bus.cpu_en);
    else n_pass++;
    tick(1);
    n_checks++;
    if (bus.state !== 2'd0 || bus.cpu_en !== 1'b0)
      $display("FAIL halt_stop state=%0d cpu_en=%b expected 0/0", bus.state, bus.cpu_en);
    else n_pass++;
    model_cnt += 10;
    n_checks++;
    if (bus.cycle_cnt !== CW'(model_cnt)) $display("FAIL div0_count cnt=%0d expected %0d", bus.cycle_cnt, CW'(model_cnt));
    else n_pass++;
    bus.halt_btn = 1'b0;
    tick(3);
  endtask

  task automatic test_run_step_same();
    int pulses = 0; bit saw_run = 1'b0; int exp;
    exp_q.push_back(model_cnt);
    bus.run_btn  = 1'b1;
    bus.step_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.state === 2'd1) saw_run = 1'b1;
      if (bus.cpu_en === 1'b1) begin
        pulses++;
        n_checks++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        if (bus.cycle_cnt !== CW'(exp) || exp < 0)
          $display("FAIL prio_pulse cnt=%0d expected %0d", bus.cycle_cnt, CW'(exp));
        else n_pass++;
      end
    end
    bus.run_btn  = 1'b0;
    bus.step_btn = 1'b0;
    tick(3);
    exp_q.delete();
    model_cnt += 1;
    n_checks++;
    if (pulses != 1 || saw_run || bus.state !== 2'd0)
      $display("FAIL prio_step_over_run pulses=%0d saw_run=%b state=%0d expected 1/0/0",
               pulses, saw_run, bus.state);
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit seen; int waited; int exp;
    while ((model_cnt % 16) != 0) begin
      exp_q.push_back(model_cnt);
      bus.step_btn = 1'b1;
      wait_pulse(8, seen, waited);
      n_checks++;
      if (!seen) begin
        $display("FAIL wrap_step timeout after %0d clk, expected a strobe", waited);
        exp_q.delete();
      end else begin
        exp = exp_q.pop_front();
        if (bus.cycle_cnt !== CW'(exp)) $display("FAIL wrap_step cnt=%0d expected %0d", bus.cycle_cnt, CW'(exp));
        else n_pass++;
      end
      bus.step_btn = 1'b0;
      tick(4);
      model_cnt++;
    end
    n_checks++;
    if (bus.cycle_cnt !== CW'(0)) $display("FAIL cnt_wrap cnt=%0d expected 0", bus.cycle_cnt);
    else n_pass++;
  endtask

  task automatic test_div_lower();
    int highs = 0;
    bus.div_sel = DW'(20);
    bus.run_btn = 1'b1;
    tick(3);
    bus.run_btn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (bus.cpu_en === 1'b1) highs++;
    end
    bus.div_sel = DW'(2);
    tick(1);
    n_checks++;
    if (highs != 0 || bus.cpu_en !== 1'b1)
      $display("FAIL div_lower_fire early_pulses=%0d cpu_en=%b expected 0/1", highs, bus.cpu_en);
    else n_pass++;
    bus.halt_btn = 1'b1;
    tick(4);
    bus.halt_btn = 1'b0;
    model_cnt += 1;
    n_checks++;
    if (bus.state !== 2'd0 || bus.cycle_cnt !== CW'(model_cnt))
      $display("FAIL div_lower_halt state=%0d cnt=%0d expected 0/%0d", bus.state, bus.cycle_cnt, CW'(model_cnt));
    else n_pass++;
    tick(3);
  endtask

  task automatic test_async_reset();
    bus.div_sel = '0;
    bus.run_btn = 1'b1;
    tick(3);
    bus.run_btn = 1'b0;
    tick(2);
    n_checks++;
    if (bus.cpu_en !== 1'b1) $display("FAIL areset_pre cpu_en=%b expected 1", bus.cpu_en);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.cpu_en !== 1'b0 || bus.state !== 2'd0 || bus.cycle_cnt !== CW'(0))
      $display("FAIL areset_immediate cpu_en=%b state=%0d cnt=%0d expected 0/0/0",
               bus.cpu_en, bus.state, bus.cycle_cnt);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_cnt = 0;
    tick(2);
  endtask

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  task automatic test_breakpoint();
    int pulses = 0; int waited = 0; bit seen; int exp;
    bus.bp_addr  = PW'(2);
    bus.bp_valid = 1'b1;
    bus.div_sel  = DW'(3);
    exp_q.push_back(0);
    exp_q.push_back(1);
    bus.run_btn = 1'b1;
    tick(3);
    bus.run_btn = 1'b0;
    while (bus.state !== 2'd3 && waited < 40) begin
      tick(1);
      waited++;
      if (bus.cpu_en === 1'b1) begin
        pulses++;
        n_checks++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        if (exp < 0 || bus.cycle_cnt !== CW'(exp))
          $display("FAIL bp_run_pulse cnt=%0d expected %0d", bus.cycle_cnt, CW'(exp));
        else n_pass++;
      end
    end
    exp_q.delete();
    n_checks++;
    if (bus.state !== 2'd3 || bus.bp_hit !== 1'b1 || bus.cycle_cnt !== CW'(2) || pulses != 2 || bus.cpu_en !== 1'b0)
      $display("FAIL bp_stop state=%0d bp_hit=%b cnt=%0d pulses=%0d expected 3/1/2/2",
               bus.state, bus.bp_hit, bus.cycle_cnt, pulses);
    else n_pass++;
    bus.run_btn = 1'b1;
    wait_pulse(12, seen, waited);
    bus.run_btn = 1'b0;
    n_checks++;
    if (!seen || bus.bp_hit !== 1'b0 || bus.state !== 2'd1)
      $display("FAIL bp_resume seen=%b bp_hit=%b state=%0d expected 1/0/1", seen, bus.bp_hit, bus.state);
    else n_pass++;
    tick(1);
    n_checks++;
    if (bus.cycle_cnt !== CW'(3)) $display("FAIL bp_resume_cnt cnt=%0d expected 3", bus.cycle_cnt);
    else n_pass++;
    bus.bp_valid = 1'b0;
    do_halt();
  endtask
`else
  task automatic test_breakpoint();
    int pulses = 0; bit saw_bp = 1'b0;
    bus.bp_addr  = PW'(2);
    bus.bp_valid = 1'b1;
    bus.div_sel  = DW'(3);
    bus.run_btn  = 1'b1;
    tick(3);
    bus.run_btn = 1'b0;
    for (int i = 0; i < 27; i++) begin
      tick(1);
      if (bus.cpu_en === 1'b1) pulses++;
      if (bus.bp_hit !== 1'b0 || bus.state === 2'd3) saw_bp = 1'b1;
    end
    n_checks++;
    if (saw_bp || pulses != 6)
      $display("FAIL bp_disabled saw_break=%b pulses=%0d expected 0/6", saw_bp, pulses);
    else n_pass++;
    bus.bp_valid = 1'b0;
    do_halt();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_run_rate();
    test_step_hold();
    test_div_zero_halt();
    test_run_step_same();
    test_wrap();
    test_div_lower();
    test_async_reset();
    test_breakpoint();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
